// File: rtl/west_buffer_reader.sv
// west_buffer_reader: sweeps the WEST Qn buffer through port B and streams each word to the array,
// repeating the sweep num_passes times behind a two-entry skid FIFO with full backpressure.
package top_pkg;
   localparam int TOP_CHUNK_SIZE = 4;
endpackage

module west_buffer_reader #(
   parameter int WIDTH = 16,
   parameter int NUM_CORES_A = 2,
   parameter int NUM_CORES_B = 1,
   parameter int COL_X = 16,
   parameter int TOTAL_INPUT_W = 2,
   parameter int CHUNK_SIZE = top_pkg::TOP_CHUNK_SIZE,
   localparam int MODULE_WIDTH = WIDTH * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B,
   localparam int TOTAL_DEPTH = COL_X * TOTAL_INPUT_W,
   localparam int ADDR_WIDTH = $clog2(TOTAL_DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [7:0]              num_passes,
   output logic                    rd_en,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   input  logic [MODULE_WIDTH-1:0] rd_data,
   output logic [MODULE_WIDTH-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic                    busy,
   output logic                    done
);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
   state_t state, state_nx;

   logic [ADDR_WIDTH-1:0]   addr, addr_q;
   logic [7:0]              passes, pass_cnt;
   logic                    inflight, inflight_last;
   logic [1:0]              occ;
   logic                    wptr, rptr;
   logic [MODULE_WIDTH-1:0] fifo_d [2];
   logic                    fifo_l [2];
   logic                    pop, pop_fifo, push, last_addr, last_rd;

   // The word returning from port B bypasses the FIFO when it is empty, hiding the read latency.
   assign out_valid = occ != 2'd0 || inflight;
   assign out_data  = occ != 2'd0 ? fifo_d[rptr] : inflight ? rd_data : '0;
   assign out_last  = occ != 2'd0 ? fifo_l[rptr] : inflight && inflight_last;
   assign pop       = out_valid && out_ready;
   assign pop_fifo  = pop && occ != 2'd0;
   assign push      = inflight && !(occ == 2'd0 && pop);
   assign last_addr = addr == LAST_ADDR;
   assign rd_en     = state == READ && ({1'b0, occ} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
   assign last_rd   = rd_en && last_addr && pass_cnt == passes - 8'd1;
   assign rd_addr   = rd_en ? addr : addr_q;
   assign busy      = state == READ || state == DRAIN;
   assign done      = state == DONE;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  state_nx = start ? READ : IDLE;
         READ:  state_nx = last_rd ? DRAIN : READ;
         DRAIN: state_nx = ({1'b0, occ} + {2'b0, inflight} == {2'b0, pop}) ? DONE : DRAIN;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         addr          <= '0;
         addr_q        <= '0;
         passes        <= 8'd1;
         pass_cnt      <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         occ           <= '0;
         wptr          <= 1'b0;
         rptr          <= 1'b0;
      end else begin
         state         <= state_nx;
         inflight      <= rd_en;
         inflight_last <= rd_en && last_addr;
         if (state == IDLE && start) begin
            passes   <= num_passes == 8'd0 ? 8'd1 : num_passes;
            addr     <= '0;
            pass_cnt <= '0;
         end else if (rd_en) begin
            addr     <= last_addr ? '0 : addr + 1'b1;
            addr_q   <= addr;
            pass_cnt <= last_addr ? pass_cnt + 8'd1 : pass_cnt;
         end
         occ  <= occ + {1'b0, push} - {1'b0, pop_fifo};
         wptr <= push ? ~wptr : wptr;
         rptr <= pop_fifo ? ~rptr : rptr;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_d[wptr] <= rd_data;
         fifo_l[wptr] <= inflight_last;
      end
   end
endmodule

// File: tb/tb_west_buffer_reader.sv
// tb_west_buffer_reader: directed checks of the WEST buffer read sequencer against a depth-8 buffer model.
module tb_west_buffer_reader;
   localparam int W = 128;
   localparam int D = 8;
   localparam int AW = 3;

   logic          clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
   logic [7:0]    num_passes = 8'd0;
   logic          rd_en, out_valid, out_last, busy, done;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  rd_data = '0, out_data;
   logic [W-1:0]  mem [D];
   int            tests = 0, fails = 0;

   west_buffer_reader #(
      .WIDTH(16), .NUM_CORES_A(2), .NUM_CORES_B(1), .COL_X(4), .TOTAL_INPUT_W(2), .CHUNK_SIZE(4)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .num_passes(num_passes),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic want);
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, want);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int want);
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chkb({tag, "_rd_en"}, rd_en, 1'b0);
      chki({tag, "_rd_addr"}, int'(rd_addr), 0);
      chkb({tag, "_valid"}, out_valid, 1'b0);
      chk({tag, "_data"}, out_data, '0);
      chkb({tag, "_last"}, out_last, 1'b0);
      chkb({tag, "_busy"}, busy, 1'b0);
      chkb({tag, "_done"}, done, 1'b0);
   endtask

   // mode 0: ready always high; mode 1: random ready with a 5-cycle stall; mode 2: stray start and num_passes change
   task automatic stream(input logic [7:0] np, input int n, input int mode);
      int beats = 0, issued = 0, cyc = 0, done_cyc = -1;
      logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
      logic [W-1:0] pd = '0;
      @(posedge clk);
      #2 start = 1'b1; num_passes = np; out_ready = 1'b1;
      while (done_cyc < 0 && cyc < 400) begin
         @(posedge clk);
         #2;
         cyc++;
         start = mode == 2 && cyc == 4;
         if (mode == 2 && cyc == 4) num_passes = 8'd5;
         out_ready = mode == 1 ? ((cyc >= 6 && cyc <= 10) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
         #2;
         if (cyc == 1) begin
            chkb("first_rd_en", rd_en, 1'b1);
            chkb("first_valid", out_valid, 1'b0);
         end
         if (pv && !pr) begin
            chkb("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, pd);
            chkb("stall_last", out_last, pl);
         end
         if (rd_en) begin
            chki("rd_addr", int'(rd_addr), issued % D);
            issued++;
         end
         chkb("credit", (issued - beats - int'(out_valid && out_ready)) <= 2, 1'b1);
         if (out_valid && out_ready) begin
            chk("data", out_data, W'(beats % D));
            chkb("last", out_last, beats % D == D - 1);
            if (mode == 0) chki("beat_cycle", cyc, beats + 2);
            beats++;
         end
         if (done) begin
            done_cyc = cyc;
            chkb("busy_at_done", busy, 1'b0);
         end else chkb("busy", busy, 1'b1);
         pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      end
      start = 1'b0;
      chkb("done_seen", done_cyc >= 0, 1'b1);
      chki("beat_count", beats, n);
      chki("read_count", issued, n);
      if (mode != 1) chki("done_cycle", done_cyc, n + 2);
      @(posedge clk);
      #4;
      chkb("done_pulse", done, 1'b0);
      chkb("idle_busy", busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < D; k++) mem[k] = W'(k);
      repeat (2) @(posedge clk);
      #4 chk_idle_outputs("reset");
      @(posedge clk);
      #3 rst = 1'b0;

      stream(8'd1, 8, 0);
      stream(8'd3, 24, 0);
      stream(8'd0, 8, 0);
      stream(8'd1, 8, 1);
      stream(8'd2, 16, 1);
      stream(8'd1, 8, 2);

      @(posedge clk);
      #2 start = 1'b1; num_passes = 8'd1; out_ready = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk);
         #2 start = 1'b0;
         #2;
      end
      chk("pre_reset_beat4", out_data, W'(4));
      #1 rst = 1'b1;
      #1 chk_idle_outputs("async_reset");
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #4 chkb("no_done_in_reset", done, 1'b0);
      end
      @(posedge clk);
      #3 rst = 1'b0;
      #1 chk_idle_outputs("after_reset");
      stream(8'd1, 8, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
